// File: rtl/fifo_pkg.sv
// =====================================================================
// fifo_pkg: shared read-mode constants, defaults and parameter check
// Revision 1.0
// =====================================================================
`default_nettype none

package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  localparam int FIFO_DEF_WIDTH = 16;
  localparam int FIFO_DEF_DEPTH = 8;

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// Elaboration-time guard on geometry and threshold ordering.
`define FIFO_PARAM_CHECK(DEP, AE, AF) \
  if (!fifo_pkg::is_pow2(DEP) || !((AE) < (AF)) || !((AF) <= (DEP))) begin : g_param_check \
    $error("fifo: DEPTH must be a power of two >= 2 and AE_THRESH < AF_THRESH <= DEPTH"); \
  end

`default_nettype wire

// File: rtl/fifo_mem_ram.sv
// =====================================================================
// fifo_mem_ram: WIDTH x DEPTH storage, synchronous write, async read
// Revision 1.0
// =====================================================================
`default_nettype none

module fifo_mem_ram #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// =====================================================================
// sync_fifo_param: single-clock FIFO, registered or FWFT read mode
// Revision 1.0
// =====================================================================
`default_nettype none

module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_DEF_WIDTH,
  parameter int DEPTH     = FIFO_DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = FIFO_MODE_REG
) (
  input  logic                     clk_1,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         data_1,
  input  logic                     data_1_en,
  input  logic                     data_2_ready,
  output logic [WIDTH-1:0]         data_2,
  output logic                     data_2_valid,
  output logic                     buffer_empty,
  output logic                     buffer_full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   buffer_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_af    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] c_ae    = CNT_W'(AE_THRESH);

  `FIFO_PARAM_CHECK(DEPTH, AE_THRESH, AF_THRESH)

  logic [ADDR_W:0]    r_wr_ptr;
  logic [ADDR_W:0]    r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_empty;
  logic               w_full;
  logic               w_wr;
  logic               w_rd;
  logic [ADDR_W:0]    w_wr_ptr_nxt;
  logic [ADDR_W:0]    w_rd_ptr_nxt;
  logic [WIDTH-1:0]   w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);

  // Both modes accept a read only when a word is present; in FWFT this is valid && ready.
  assign w_wr = data_1_en && !w_full;
  assign w_rd = data_2_ready && !w_empty;

  assign w_wr_ptr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_wr};
  assign w_rd_ptr_nxt = r_rd_ptr + {{ADDR_W{1'b0}}, w_rd};

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
      if (data_1_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if ((FWFT == FIFO_MODE_REG) && data_2_ready && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  fifo_mem_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk_1),
    .i_wr_en   (w_wr && !flush),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (data_1),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (w_head)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft_read
      // Head word is gated to zero while empty so reset and flush present a clean bus.
      assign data_2       = w_empty ? '0 : w_head;
      assign data_2_valid = !w_empty;
    end else begin : g_reg_read
      logic [WIDTH-1:0] r_data;
      logic             r_valid;

      always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else if (flush) begin
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_rd;
          if (w_rd) begin
            r_data <= w_head;
          end
        end
      end

      assign data_2       = r_data;
      assign data_2_valid = r_valid;
    end
  endgenerate

  assign buffer_empty = w_empty;
  assign buffer_full  = w_full;
  assign almost_empty = (r_count <= c_ae);
  assign almost_full  = (r_count >= c_af);
  assign buffer_count = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// =====================================================================
// tb_sync_fifo_param: registered and FWFT instances against queue models
// Revision 1.0
// =====================================================================
`default_nettype none

module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] data_1 = '0;
  logic        data_1_en = 1'b0;
  logic        data_2_ready = 1'b0;

  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid, a_empty, b_empty, a_full, b_full;
  logic        a_ae, b_ae, a_af, b_af, a_ovf, b_ovf, a_udf, b_udf;
  logic [3:0]  a_count, b_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: plain queues plus the registered-mode output latch.
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] ea_data;
  bit          ea_valid, ea_ovf, ea_udf, eb_ovf;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) u_reg (
    .clk_1(clk), .rst(rst), .flush(flush), .data_1(data_1), .data_1_en(data_1_en),
    .data_2_ready(data_2_ready), .data_2(a_data), .data_2_valid(a_valid),
    .buffer_empty(a_empty), .buffer_full(a_full), .almost_empty(a_ae), .almost_full(a_af),
    .buffer_count(a_count), .overflow(a_ovf), .underflow(a_udf)
  );

  sync_fifo_param #(.WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) u_fwft (
    .clk_1(clk), .rst(rst), .flush(flush), .data_1(data_1), .data_1_en(data_1_en),
    .data_2_ready(data_2_ready), .data_2(b_data), .data_2_valid(b_valid),
    .buffer_empty(b_empty), .buffer_full(b_full), .almost_empty(b_ae), .almost_full(b_af),
    .buffer_count(b_count), .overflow(b_ovf), .underflow(b_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    ea_data = '0; ea_valid = 0; ea_ovf = 0; ea_udf = 0; eb_ovf = 0;
  endtask

  task automatic check_all();
    int sa, sb;
    sa = qa.size();
    sb = qb.size();
    chk("reg.data_2",       32'(a_data),  32'(ea_data));
    chk("reg.data_2_valid", 32'(a_valid), 32'(ea_valid));
    chk("reg.count",        32'(a_count), 32'(sa));
    chk("reg.empty",        32'(a_empty), 32'(sa == 0));
    chk("reg.full",         32'(a_full),  32'(sa == 8));
    chk("reg.almost_empty", 32'(a_ae),    32'(sa <= 1));
    chk("reg.almost_full",  32'(a_af),    32'(sa >= 6));
    chk("reg.overflow",     32'(a_ovf),   32'(ea_ovf));
    chk("reg.underflow",    32'(a_udf),   32'(ea_udf));
    chk("fwft.data_2",       32'(b_data),  (sb > 0) ? 32'(qb[0]) : 32'd0);
    chk("fwft.data_2_valid", 32'(b_valid), 32'(sb > 0));
    chk("fwft.count",        32'(b_count), 32'(sb));
    chk("fwft.empty",        32'(b_empty), 32'(sb == 0));
    chk("fwft.full",         32'(b_full),  32'(sb == 8));
    chk("fwft.almost_empty", 32'(b_ae),    32'(sb <= 1));
    chk("fwft.almost_full",  32'(b_af),    32'(sb >= 6));
    chk("fwft.overflow",     32'(b_ovf),   32'(eb_ovf));
    chk("fwft.underflow",    32'(b_udf),   32'd0);
  endtask

  // One clock: drive, apply the FIFO rules to the queues at the edge, check 1ns later.
  task automatic step(input bit en, input logic [15:0] d, input bit rdy, input bit fl);
    bit a_full_m, a_empty_m, b_full_m, b_empty_m;
    data_1_en = en; data_1 = d; data_2_ready = rdy; flush = fl;
    @(posedge clk);
    a_full_m  = (qa.size() == 8); a_empty_m = (qa.size() == 0);
    b_full_m  = (qb.size() == 8); b_empty_m = (qb.size() == 0);
    if (fl) begin
      qa.delete(); qb.delete();
      ea_valid = 0; ea_ovf = 0; ea_udf = 0; eb_ovf = 0;
    end else begin
      ea_valid = 0;
      if (rdy && !a_empty_m) begin ea_data = qa.pop_front(); ea_valid = 1; end
      if (rdy && a_empty_m) ea_udf = 1;
      if (en && a_full_m) ea_ovf = 1;
      if (en && !a_full_m) qa.push_back(d);
      if (rdy && !b_empty_m) void'(qb.pop_front());
      if (en && b_full_m) eb_ovf = 1;
      if (en && !b_full_m) qb.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // Fill with 0xA000..0xA007, overflow attempt, drain, then reads on empty.
    for (int i = 0; i < 8; i++) step(1, 16'hA000 + 16'(i), 0, 0);
    step(1, 16'hBEEF, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 16'h0, 1, 0);
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 0, 1);

    // Steady-state streaming at count 4 across several pointer wraps.
    for (int i = 0; i < 4; i++) step(1, 16'hC000 + 16'(i), 0, 0);
    for (int i = 1; i <= 20; i++) step(1, 16'(i), 1, 0);
    step(0, 16'h0, 0, 1);

    // Single word: fall-through, held for three cycles, then popped.
    step(1, 16'h1234, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 0, 0);
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 0, 0);

    // Threshold walk 0..8, drain to 5, flush with a colliding write.
    for (int i = 0; i < 8; i++) step(1, 16'hD000 + 16'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0);
    step(1, 16'hDEAD, 0, 1);
    step(0, 16'h0, 0, 0);

    // Asynchronous reset mid-burst at count 3, then recovery.
    for (int i = 0; i < 3; i++) step(1, 16'hE000 + 16'(i), 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #3 rst = 1'b0;
    step(1, 16'h5A5A, 0, 0);
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 0, 0);

    // Randomised traffic: fill-biased, drain-biased, then balanced, with rare flushes.
    for (int i = 0; i < 450; i++) begin
      int pw, pr;
      pw = (i < 150) ? 75 : (i < 300) ? 25 : 50;
      pr = 100 - pw;
      step(($urandom % 100) < pw, 16'($urandom), ($urandom % 100) < pr, ($urandom % 50) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the 16-bit, 8-entry buffer wrapper.
- Configurable width, depth, almost-full/almost-empty thresholds and read mode (registered or first-word-fall-through).
- Adds a consumer handshake, an occupancy count, sticky overflow/underflow flags and a synchronous flush.
- Sits between a producer and consumer sharing one clock domain.

Parameters:
- WIDTH, 16, data width in bits.
- DEPTH, 8, number of entries; power of two, ≥2.
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH.
- FWFT, 0, read mode: 0 = registered read (1-cycle latency); 1 = first-word-fall-through.

Ports:
- clk_1  in  1  sole clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of pointers and flags.
- data_1  in  WIDTH  write data.
- data_1_en  in  1  write request.
- data_2_ready  in  1  consumer read request (FWFT=0) or accept (FWFT=1).
- data_2  out  WIDTH  read data.
- data_2_valid  out  1  data_2 holds a dequeued or head word.
- buffer_empty  out  1  count == 0.
- buffer_full  out  1  count == DEPTH.
- almost_empty  out  1  count ≤ AE_THRESH.
- almost_full  out  1  count ≥ AF_THRESH.
- buffer_count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty (FWFT=0 only).

Behaviour:
- Reset: one clock clk_1; rst is asynchronous and active-high. On rst, pointers=0, buffer_count=0, buffer_empty=1, buffer_full=0, almost_empty=1, almost_full=(AF_THRESH==0), data_2=0, data_2_valid=0, overflow=0, underflow=0. Memory contents are not cleared.
- Pointers: wr_ptr/rd_ptr are ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)) and wrap naturally. buffer_count = wr_ptr − rd_ptr, registered.
- Flags: all status flags derive from the registered count and change in the cycle after the causing edge.
- Write accept: data_1_en && !buffer_full, sampled before the edge. Writes mem[wr_ptr[ADDR_W-1:0]] and increments wr_ptr.
- Write while full: data is dropped, the pointer is unchanged and overflow sets. A simultaneous read does not free space for that same-cycle write.
- Read accept, FWFT=0: data_2_ready && !buffer_empty. data_2 <= head and data_2_valid=1 on the next edge, a 1-cycle pulse per accepted read. data_2 holds its value otherwise. data_2_ready while empty sets underflow and data_2_valid stays 0.
- Read accept, FWFT=1: data_2 = mem[rd_ptr] (combinational) and data_2_valid = !buffer_empty. Pop occurs when data_2_valid && data_2_ready. data_2_ready while empty is legal and does not set underflow.
- Simultaneous read and write:
  - 0<count<DEPTH: both occur and count is unchanged.
  - Empty: only the write occurs; in FWFT=1 the word appears on data_2 the next cycle.
  - Full: only the read occurs.
- Flush: has priority over same-cycle read and write. Pointers, count, data_2_valid, overflow and underflow clear; data_2 is held.
- Reset mid-operation: asynchronous clear to the reset values above. Any in-flight read or write is discarded.
- Sticky flags: clear only on rst or flush.

Decomposition:
- fifo_pkg:
  - read-mode constants FIFO_MODE_REG=0 and FIFO_MODE_FWFT=1;
  - default WIDTH/DEPTH constants;
  - a parameter-check macro asserting DEPTH is a power of two and AE_THRESH < AF_THRESH ≤ DEPTH.
- Sub-module fifo_mem_ram: WIDTH×DEPTH array with a synchronous write port and an asynchronous read port.
- Pointer, count, flag and read-mode logic stay in sync_fifo_param.

Test Plan:
- Defaults (FWFT=0): write 0xA000..0xA007 on consecutive cycles → buffer_full=1 after the 8th. Then 8 reads → data_2 = 0xA000..0xA007, each valid one cycle after its ready, and buffer_empty=1 at the end.
- Full + write 0xBEEF → overflow=1, count stays 8, and the 8th read returns 0xA007, never 0xBEEF. Reads on empty → underflow=1, data_2_valid=0.
- Simultaneous write/read at count=4 for 20 cycles (data 0x0001..0x0014) → count stays 4, order preserved, and pointer wrap is exercised twice.
- FWFT=1: write 0x1234 into an empty FIFO → next cycle data_2=0x1234, data_2_valid=1. Hold data_2_ready=0 for 3 cycles → data_2 stable; ready=1 → pop, buffer_empty=1.
- Thresholds AF_THRESH=6, AE_THRESH=1: fill 0→8 → almost_empty deasserts at count 2 and almost_full asserts at count 6. Flush at count 5 with simultaneous write → count=0, flags at reset values, write dropped.
- Assert rst asynchronously mid-burst at count 3 → outputs reach their reset values before the next clk_1 edge, and a following write/read of 0x5A5A returns 0x5A5A.
